// File: rtl/hex_disp_pkg.sv
// -----------------------------------------------------------------------------
// hex_disp_pkg
// Shared types and constants for the multi-digit 7-segment display controller.
//   state_t    : controller FSM states
//   MODE_*     : write mode encoding (hex / decimal)
//   SEG_*      : active-high glyphs (bit 0 = seg a ... bit 6 = seg g)
//   BCD_DIGITS : digits held by the binary-to-BCD converter (covers 32-bit values)
//   seg_encode : nibble -> active-high segment pattern (0-9, A, b, C, d, E, F)
// -----------------------------------------------------------------------------
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam int BCD_DIGITS = 10;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one add-3-then-shift step per clock,
// exactly DATA_W steps after a start pulse.
//   clk, reset : clock and synchronous active-high reset (aborts a conversion)
//   start      : load data and begin a conversion (restarts if already running)
//   data       : unsigned binary input, sampled with start
//   done       : high in the cycle whose closing edge performs the final step;
//                bcd is complete after that edge and held until the next start
//   bcd        : BCD_DIGITS packed BCD digits, digit i at [4i+3:4i]
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import hex_disp_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_W-1:0]       data,
    output logic                    done,
    output logic [BCD_DIGITS*4-1:0] bcd
);

    localparam int               CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);
    localparam int               SH_W      = BCD_DIGITS * 4 + DATA_W;

    logic [DATA_W-1:0]       bin_r;
    logic [BCD_DIGITS*4-1:0] bcd_r;
    logic [BCD_DIGITS*4-1:0] adj_s;
    logic [SH_W-1:0]         shift_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    run_r;

    // add 3 to every BCD digit of 5 or more, then shift the whole {bcd, bin} left
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        shift_s = {adj_s, bin_r} << 1;
    end

    // load on start, then step until the last of DATA_W shifts
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b0;
        end else if (start) begin
            bin_r <= data;
            bcd_r <= '0;
            cnt_r <= '0;
            run_r <= 1'b1;
        end else if (run_r) begin
            {bcd_r, bin_r} <= shift_s;
            cnt_r          <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_STEP) begin
                run_r <= 1'b0;
            end else begin
                run_r <= 1'b1;
            end
        end else begin
            run_r <= 1'b0;
        end
    end

    assign done = run_r && (cnt_r == LAST_STEP);
    assign bcd  = bcd_r;

endmodule

// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
// NUM_DIGITS-wide 7-segment driver for the DE2 HEX banks. A value written over
// the strobe interface is shown in hex, or in decimal after a sequential
// binary-to-BCD conversion, with optional leading-zero blanking and an
// all-dash overflow indication. One pending write is buffered while busy.
//   CLOCK_50    : clock, rising edge
//   reset       : synchronous active-high reset
//   wr_en       : one-cycle write strobe; wr_data/wr_mode/wr_blank_lz sampled with it
//   blink_mask  : per-digit blink enable (used only with HEX_DISP_BLINK_EN)
//   busy        : decimal conversion in progress
//   overflow    : displayed value does not fit in NUM_DIGITS digits
//   hex_out     : digit k at [7k+6:7k], bit 0 = seg a ... bit 6 = seg g
// Build option: define HEX_DISP_BLINK_EN to add the blink timebase and masking.
// -----------------------------------------------------------------------------
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int BLINK_DIV  = 25_000_000
)
(
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_mode,
    input  logic                    wr_blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    busy,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int EXT_W = 4 * NUM_DIGITS + DATA_W;

    state_t                      state_r, state_next_s;
    logic [DATA_W-1:0]           cur_data_r, pend_data_r, job_data_s;
    logic                        cur_mode_r, pend_mode_r, job_mode_s;
    logic                        cur_blz_r, pend_blz_r, job_blz_s;
    logic                        pend_valid_r;
    logic                        take_s, pend_wr_s, pend_clr_s, commit_s;
    logic                        conv_start_s, conv_done_s;
    logic [BCD_DIGITS*4-1:0]     conv_bcd_s;
    logic [EXT_W-1:0]            hex_ext_s;
    logic [NUM_DIGITS-1:0][3:0]  nib_s;
    logic [3:0]                  msd_s;
    logic                        ovf_next_s;
    logic [7*NUM_DIGITS-1:0]     seg_next_s, seg_r, disp_s;
    logic                        ovf_r, busy_r;

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk   (CLOCK_50),
        .reset (reset),
        .start (conv_start_s),
        .data  (job_data_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // FSM next state, job selection (new write or pending entry) and pending-slot control
    always_comb begin
        state_next_s = state_r;
        take_s       = 1'b0;
        job_data_s   = wr_data;
        job_mode_s   = wr_mode;
        job_blz_s    = wr_blank_lz;
        pend_wr_s    = 1'b0;
        pend_clr_s   = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (wr_en) begin
                    // a fresh write supersedes anything still pending
                    take_s     = 1'b1;
                    pend_clr_s = pend_valid_r;
                end else if (pend_valid_r) begin
                    take_s     = 1'b1;
                    pend_clr_s = 1'b1;
                    job_data_s = pend_data_r;
                    job_mode_s = pend_mode_r;
                    job_blz_s  = pend_blz_r;
                end else begin
                    take_s = 1'b0;
                end
            end
            CONVERT: begin
                pend_wr_s = wr_en;
                if (conv_done_s) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = CONVERT;
                end
            end
            COMMIT: begin
                commit_s     = 1'b1;
                pend_wr_s    = wr_en;
                state_next_s = IDLE;
                if (pend_valid_r) begin
                    take_s     = 1'b1;
                    pend_clr_s = 1'b1;
                    job_data_s = pend_data_r;
                    job_mode_s = pend_mode_r;
                    job_blz_s  = pend_blz_r;
                end else begin
                    take_s = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (take_s) begin
            state_next_s = (job_mode_s == MODE_DEC) ? CONVERT : COMMIT;
        end else begin
            state_next_s = state_next_s;
        end
    end

    assign conv_start_s = take_s && (job_mode_s == MODE_DEC);

    // state register and current-job latch
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r    <= IDLE;
            cur_data_r <= '0;
            cur_mode_r <= MODE_HEX;
            cur_blz_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (take_s) begin
                cur_data_r <= job_data_s;
                cur_mode_r <= job_mode_s;
                cur_blz_r  <= job_blz_s;
            end
        end
    end

    // one-entry pending slot: a write always wins over a same-cycle consume
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= '0;
            pend_mode_r  <= MODE_HEX;
            pend_blz_r   <= 1'b0;
        end else if (pend_wr_s) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= wr_data;
            pend_mode_r  <= wr_mode;
            pend_blz_r   <= wr_blank_lz;
        end else if (pend_clr_s) begin
            pend_valid_r <= 1'b0;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    // digit extraction, overflow, leading-zero blanking and glyph encoding
    always_comb begin
        hex_ext_s  = EXT_W'(cur_data_r);
        nib_s      = '0;
        msd_s      = 4'd0;
        seg_next_s = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (cur_mode_r == MODE_DEC) begin
                nib_s[k] = conv_bcd_s[4*k +: 4];
            end else begin
                nib_s[k] = hex_ext_s[4*k +: 4];
            end
        end
        if (cur_mode_r == MODE_DEC) begin
            ovf_next_s = (conv_bcd_s >> (4 * NUM_DIGITS)) != '0;
        end else begin
            ovf_next_s = (hex_ext_s >> (4 * NUM_DIGITS)) != '0;
        end
        // msd_s stays 0 for a zero value so digit 0 is never blanked
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (nib_s[k] != 4'd0) begin
                msd_s = 4'(k);
            end else begin
                msd_s = msd_s;
            end
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ovf_next_s) begin
                seg_next_s[7*k +: 7] = SEG_DASH;
            end else if (cur_blz_r && (4'(k) > msd_s)) begin
                seg_next_s[7*k +: 7] = SEG_BLANK;
            end else begin
                seg_next_s[7*k +: 7] = seg_encode(nib_s[k]);
            end
        end
    end

    // display, overflow and busy registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            seg_r  <= {NUM_DIGITS{SEG_BLANK}};
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            if (commit_s) begin
                seg_r <= seg_next_s;
                ovf_r <= ovf_next_s;
            end
            // lags the FSM by one cycle so busy covers the commit of a decimal job
            busy_r <= (state_r == CONVERT) ||
                      ((state_r == COMMIT) && (cur_mode_r == MODE_DEC));
        end
    end

`ifdef HEX_DISP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_off_r;

    // free-running blink timebase, phase toggles every BLINK_DIV cycles
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            blink_cnt_r <= '0;
            blink_off_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_r <= '0;
            blink_off_r <= ~blink_off_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // blank masked digits during the off phase
    always_comb begin
        disp_s = seg_r;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (blink_off_r && blink_mask[k]) begin
                disp_s[7*k +: 7] = SEG_BLANK;
            end else begin
                disp_s[7*k +: 7] = seg_r[7*k +: 7];
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{blink_mask, 32'(BLINK_DIV)};

    // no blinking: the registered display passes straight through
    always_comb begin
        disp_s = seg_r;
    end
`endif

    assign hex_out  = ACTIVE_LOW ? ~disp_s : disp_s;
    assign overflow = ovf_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_mode = 1'b0;
    logic        wr_blank_lz = 1'b0;
    logic [7:0]  blink_mask = 8'd0;
    logic        busy;
    logic        overflow;
    logic [55:0] hex_out;

    int total = 0;
    int bad = 0;

    hex_display_ctrl #(.NUM_DIGITS(8), .DATA_W(32), .ACTIVE_LOW(1'b1), .BLINK_DIV(25_000_000)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_mode     (wr_mode),
        .wr_blank_lz (wr_blank_lz),
        .blink_mask  (blink_mask),
        .busy        (busy),
        .overflow    (overflow),
        .hex_out     (hex_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic        mode;
        logic        blz;
        logic [63:0] chars;   // 8 characters, rightmost = digit 0
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [7:0] c);
        case (c)
            "0": return 7'h3F;  "1": return 7'h06;  "2": return 7'h5B;  "3": return 7'h4F;
            "4": return 7'h66;  "5": return 7'h6D;  "6": return 7'h7D;  "7": return 7'h07;
            "8": return 7'h7F;  "9": return 7'h6F;  "A": return 7'h77;  "B": return 7'h7C;
            "C": return 7'h39;  "D": return 7'h5E;  "E": return 7'h79;  "F": return 7'h71;
            "-": return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // active-low segment image of an 8-character display string
    function automatic logic [55:0] disp_of(input logic [63:0] s);
        logic [55:0] r;
        for (int k = 0; k < 8; k++) r[7*k +: 7] = ~glyph(s[8*k +: 8]);
        return r;
    endfunction

    // reference model: what an 8-digit display should read for a written value
    function automatic logic [63:0] model_chars(input logic [31:0] v, input logic dec,
                                                input logic blz, output logic ovf);
        string       hx = "0123456789ABCDEF";
        int          d[8];
        longint      rem;
        int          top;
        logic [63:0] s;
        rem = v;
        ovf = dec && (v >= 32'd100000000);
        for (int k = 0; k < 8; k++) begin
            if (dec) begin
                d[k] = int'(rem % 10);
                rem  = rem / 10;
            end else begin
                d[k] = int'((v >> (4 * k)) & 32'hF);
            end
        end
        top = 0;
        for (int k = 0; k < 8; k++) if (d[k] != 0) top = k;
        for (int k = 0; k < 8; k++) begin
            if (ovf) s[8*k +: 8] = "-";
            else if (blz && k > top) s[8*k +: 8] = " ";
            else s[8*k +: 8] = hx[d[k]];
        end
        return s;
    endfunction

    task automatic write_val(input logic [31:0] v, input logic m, input logic b);
        @(negedge clk);
        wr_en = 1'b1; wr_data = v; wr_mode = m; wr_blank_lz = b;
        @(negedge clk);
        wr_en = 1'b0; wr_data = $urandom; wr_mode = ~m; wr_blank_lz = ~b;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n >= 2 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_idle: busy still 1 after 200 cycles, required 0");
        end
    endtask

    initial begin
        logic [55:0] exp_a, exp_b, exp_c;
        logic        ovf_m;
        int          first_a, first_b, busy_cnt, low_cnt;
        bit          seen_c;

        vecs[0]  = '{32'hDEADBEEF, 1'b0, 1'b0, "DEADBEEF", 1'b0};
        vecs[1]  = '{32'h000000A5, 1'b0, 1'b1, "      A5", 1'b0};
        vecs[2]  = '{32'd12345678, 1'b1, 1'b1, "12345678", 1'b0};
        vecs[3]  = '{32'd123456789, 1'b1, 1'b0, "--------", 1'b1};
        vecs[4]  = '{32'h00000000, 1'b0, 1'b1, "       0", 1'b0};
        vecs[5]  = '{32'd0,        1'b1, 1'b0, "00000000", 1'b0};
        vecs[6]  = '{32'd99999999, 1'b1, 1'b1, "99999999", 1'b0};
        vecs[7]  = '{32'd100000000, 1'b1, 1'b1, "--------", 1'b1};
        vecs[8]  = '{32'h00F00001, 1'b0, 1'b1, "  F00001", 1'b0};
        vecs[9]  = '{32'd305,      1'b1, 1'b1, "     305", 1'b0};
        vecs[10] = '{32'hFFFFFFFF, 1'b1, 1'b0, "--------", 1'b1};
        vecs[11] = '{32'h0000000C, 1'b0, 1'b0, "0000000C", 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_hex_out", 64'(hex_out), 64'h00FFFFFFFFFFFFFF);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);

        // hex write: display changes exactly one edge after acceptance, busy stays low
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'hDEADBEEF; wr_mode = 1'b0; wr_blank_lz = 1'b0;
        @(negedge clk);
        wr_en = 1'b0; wr_data = 32'h0; wr_mode = 1'b1;
        check("hex_not_yet", 64'(hex_out), 64'h00FFFFFFFFFFFFFF);
        @(negedge clk);
        check("hex_deadbeef", 64'(hex_out), 64'(disp_of("DEADBEEF")));
        check("hex_busy_low", 64'(busy), 64'd0);

        // decimal write: busy for DATA_W+1 cycles, display updates on the last of them
        exp_a = disp_of(model_chars(32'd12345678, 1'b1, 1'b1, ovf_m));
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'd12345678; wr_mode = 1'b1; wr_blank_lz = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; wr_data = 32'd7;
        busy_cnt = 0; first_a = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (first_a < 0 && hex_out == exp_a) first_a = n;
        end
        check("dec_busy_cycles", 64'(busy_cnt), 64'd33);
        check("dec_update_cycle", 64'(first_a), 64'd33);
        check("dec_overflow", 64'(overflow), 64'd0);

        // table-driven vectors
        foreach (vecs[i]) begin
            write_val(vecs[i].value, vecs[i].mode, vecs[i].blz);
            wait_idle();
            check($sformatf("vec%0d_hex_out", i), 64'(hex_out), 64'(disp_of(vecs[i].chars)));
            check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
        end

        // randomized writes against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] v;
            logic        m, b;
            logic [63:0] s;
            m = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (m && $urandom_range(0, 3) != 0) v = $urandom_range(0, 99999999);
            else v = $urandom;
            s = model_chars(v, m, b, ovf_m);
            write_val(v, m, b);
            wait_idle();
            check($sformatf("rand%0d_hex_out v=%h m=%0d b=%0d", i, v, m, b), 64'(hex_out), 64'(disp_of(s)));
            check($sformatf("rand%0d_overflow", i), 64'(overflow), 64'(ovf_m));
        end

        // pending slot: 5 converts, 7 is superseded by 9, busy never drops
        write_val(32'hAAAAAAAA, 1'b0, 1'b0);
        wait_idle();
        exp_a = disp_of(model_chars(32'd5, 1'b1, 1'b1, ovf_m));
        exp_b = disp_of(model_chars(32'd9, 1'b1, 1'b1, ovf_m));
        exp_c = disp_of(model_chars(32'd7, 1'b1, 1'b1, ovf_m));
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'd5; wr_mode = 1'b1; wr_blank_lz = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        first_a = -1; first_b = -1; seen_c = 1'b0; low_cnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (first_a < 0 && hex_out == exp_a) first_a = n;
            if (first_b < 0 && hex_out == exp_b) first_b = n;
            if (hex_out == exp_c) seen_c = 1'b1;
            if (n <= 66 && !busy) low_cnt++;
            if (n == 2 || n == 5) begin
                wr_en = 1'b1; wr_data = (n == 2) ? 32'd7 : 32'd9; wr_mode = 1'b1; wr_blank_lz = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
        end
        check("pend_first_shows_5", 64'(first_a), 64'd33);
        check("pend_then_shows_9", 64'(first_b), 64'd66);
        check("pend_7_never_shown", 64'(seen_c), 64'd0);
        check("pend_busy_continuous", 64'(low_cnt), 64'd0);
        check("pend_final_display", 64'(hex_out), 64'(exp_b));
        check("pend_final_busy", 64'(busy), 64'd0);

        // reset mid-conversion aborts it and discards a pending write
        write_val(32'd777, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        write_val(32'd42, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_hex_out", 64'(hex_out), 64'h00FFFFFFFFFFFFFF);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_overflow", 64'(overflow), 64'd0);
        repeat (80) @(negedge clk);
        check("midreset_stays_blank", 64'(hex_out), 64'h00FFFFFFFFFFFFFF);
        check("midreset_stays_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
